// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the round-robin APB master arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_rr_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from ptr+1 upward with wrap,
// returning a one-hot grant and its encoded index.
module rr_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx
);

   int   cand;
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(ptr) + off) % NUM_REQ;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters;
// sequences SETUP/ACCESS and routes the completion back to the owner.
module apb_rr_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic                          i_clk_apb,
   input  logic                          i_rst_apb,
   input  logic [NUM_REQ-1:0]            i_valid,
   input  logic [NUM_REQ-1:0]            i_rd0_wr1,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wr_data,
   output logic [NUM_REQ-1:0]            o_ready,
   output logic [NUM_REQ-1:0]            o_rd_valid,
   output logic [NUM_REQ-1:0]            o_wr_done,
   output logic                          o_err,
   output logic [DATA_WIDTH-1:0]         o_rd_data,
   output logic                          o_psel,
   output logic                          o_penable,
   output logic                          o_pwrite,
   output logic [ADDR_WIDTH-1:0]         o_paddr,
   output logic [DATA_WIDTH-1:0]         o_pwdata,
   input  logic [DATA_WIDTH-1:0]         i_prdata,
   input  logic                          i_pready,
   input  logic                          i_pslverr
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   state_e                  state_q, state_d;
   logic [IW-1:0]           ptr_q, ptr_d, owner_q, owner_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d, rd_data_q, rd_data_d;
   logic [NUM_REQ-1:0]      rd_valid_q, rd_valid_d, wr_done_q, wr_done_d;
   logic                    err_q, err_d;
   logic [NUM_REQ-1:0]      gnt;
   logic [IW-1:0]           gnt_idx;
   logic                    accept, timeout, done;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
      .req (i_valid),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   assign o_ready = (state_q == IDLE) ? gnt : '0;
   assign accept  = |(i_valid & o_ready);
   // Timeout only fires when the slave has not answered in the final allowed cycle.
   assign timeout = (TIMEOUT_CYC > 0) && (cnt_q == CNT_LAST) && !i_pready;
   assign done    = (state_q == ACCESS) && (i_pready || timeout);

   always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
      if (i_rst_apb) begin
         state_q    <= IDLE;
         ptr_q      <= IW'(NUM_REQ - 1);
         owner_q    <= '0;
         cnt_q      <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         wr_done_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         paddr_q    <= paddr_d;
         pwdata_q   <= pwdata_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         wr_done_q  <= wr_done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = '0;
      wr_done_d  = '0;
      err_d      = 1'b0;
      unique case (state_q)
         IDLE: if (accept) begin
            ptr_d    = gnt_idx;
            owner_d  = gnt_idx;
            psel_d   = 1'b1;
            pwrite_d = i_rd0_wr1[gnt_idx];
            paddr_d  = i_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_d = i_wr_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
         end
         SETUP: begin
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ACCESS: if (done) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            err_d     = i_pready ? i_pslverr : 1'b1;
            if (pwrite_q) begin
               wr_done_d[owner_q] = 1'b1;
            end else begin
               rd_valid_d[owner_q] = 1'b1;
               rd_data_d           = i_pready ? i_prdata : '0;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign o_rd_valid = rd_valid_q;
   assign o_wr_done  = wr_done_q;
   assign o_err      = err_q;
   assign o_rd_data  = rd_data_q;
   assign o_psel     = psel_q;
   assign o_penable  = penable_q;
   assign o_pwrite   = pwrite_q;
   assign o_paddr    = paddr_q;
   assign o_pwdata   = pwdata_q;

endmodule
